// File: rtl/ram_delay_line_if.sv
// Sample-stream and latency-configuration bundle for ram_delay_line.
// The master drives samples and configuration; the slave returns the delayed stream and status.
interface ram_delay_line_if #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned ADDR_WIDTH = 8
);
    localparam int unsigned BUS_W = DATA_WIDTH * NUM_CH;

    logic                  ce;
    logic [BUS_W-1:0]      din;
    logic                  flush;
    logic                  cfg_load;
    logic [ADDR_WIDTH-1:0] cfg_latency;
    logic [ADDR_WIDTH-1:0] cur_latency;
    logic                  cfg_err;
    logic                  primed;
    logic [BUS_W-1:0]      dout;
    logic                  dout_valid;

    modport master (
        output ce, din, flush, cfg_load, cfg_latency,
        input  cur_latency, cfg_err, primed, dout, dout_valid
    );

    modport slave (
        input  ce, din, flush, cfg_load, cfg_latency,
        output cur_latency, cfg_err, primed, dout, dout_valid
    );
endinterface

// File: rtl/ram_delay_line.sv
// Block-RAM delay line with programmable latency, priming status, flush and safe latency reload.
// The write pointer free-runs; the read address trails it by the active latency.
module ram_delay_line #(
    parameter int unsigned DATA_WIDTH      = 10,
    parameter int unsigned NUM_CH          = 1,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned DEFAULT_LATENCY = 20,
    parameter int unsigned OUT_REG         = 0
) (
    input  logic              clk,
    input  logic              arst,
    ram_delay_line_if.slave   bus
);
    localparam int unsigned BUS_W = DATA_WIDTH * NUM_CH;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [BUS_W-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] fill_q, fill_d;
    logic [ADDR_WIDTH-1:0] lat_q, lat_d;
    logic                  primed_q, primed_d;
    logic                  err_q, err_d;
    logic [BUS_W-1:0]      rd_data_q;
    logic                  rd_valid_q;
    logic                  reprime_c;
    logic                  re_c;
    logic [ADDR_WIDTH-1:0] raddr_c;

    assign reprime_c = bus.flush | bus.cfg_load;
    // The sample on a reload/flush cycle is stored but its read is dropped.
    assign re_c      = bus.ce & primed_q & ~reprime_c;
    assign raddr_c   = wptr_q - lat_q;

    // Next-state for pointer, fill counter, latency and status.
    always_comb begin
        wptr_d   = wptr_q;
        fill_d   = fill_q;
        lat_d    = lat_q;
        primed_d = primed_q;
        err_d    = 1'b0;
        if (bus.ce) begin
            wptr_d = wptr_q + ADDR_WIDTH'(1);
        end
        if (bus.cfg_load) begin
            lat_d = (bus.cfg_latency == '0) ? ADDR_WIDTH'(1) : bus.cfg_latency;
            err_d = (bus.cfg_latency == '0);
        end
        if (reprime_c) begin
            fill_d   = '0;
            primed_d = 1'b0;
        end else if (bus.ce && !primed_q) begin
            fill_d   = fill_q + ADDR_WIDTH'(1);
            primed_d = (fill_d == lat_q);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wptr_q   <= '0;
            fill_q   <= '0;
            lat_q    <= ADDR_WIDTH'(DEFAULT_LATENCY);
            primed_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            fill_q   <= fill_d;
            lat_q    <= lat_d;
            primed_q <= primed_d;
            err_q    <= err_d;
        end
    end

    // Sample storage; contents are never reset, reads are gated by priming.
    always_ff @(posedge clk) begin
        if (bus.ce) begin
            mem_q[wptr_q] <= bus.din;
        end
    end

    // Read register doubles as the masked/held output stage.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= re_c;
            if (re_c) begin
                rd_data_q <= mem_q[raddr_c];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [BUS_W-1:0] out_data_q;
            logic             out_valid_q;

            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    out_data_q  <= '0;
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= rd_valid_q;
                    if (rd_valid_q) begin
                        out_data_q <= rd_data_q;
                    end
                end
            end

            assign bus.dout       = out_data_q;
            assign bus.dout_valid = out_valid_q;
        end else begin : g_no_out_reg
            assign bus.dout       = rd_data_q;
            assign bus.dout_valid = rd_valid_q;
        end
    endgenerate

    assign bus.cur_latency = lat_q;
    assign bus.cfg_err     = err_q;
    assign bus.primed      = primed_q;
endmodule

// File: tb/tb_ram_delay_line.sv
// Scoreboard bench for ram_delay_line: one instance without and one with the output register,
// both fed the same directed stream; expected samples are queued at issue and checked on dout_valid.
module tb_ram_delay_line;
    localparam int unsigned DW = 10;
    localparam int unsigned AW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk;
    logic arst;
    int   cyc = 0;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t          q0[$];
    exp_t          q1[$];
    logic [DW-1:0] hist[$];
    logic [DW-1:0] lastv[2];

    int   lm     = 20;
    int   fill_m = 0;
    bit   pm     = 1'b0;
    bit   errm   = 1'b0;
    int   k      = 0;

    ram_delay_line_if #(.DATA_WIDTH(DW), .NUM_CH(1), .ADDR_WIDTH(AW)) if0 ();
    ram_delay_line_if #(.DATA_WIDTH(DW), .NUM_CH(1), .ADDR_WIDTH(AW)) if1 ();

    ram_delay_line #(.DATA_WIDTH(DW), .NUM_CH(1), .ADDR_WIDTH(AW),
                     .DEFAULT_LATENCY(20), .OUT_REG(0)) dut0 (
        .clk (clk),
        .arst(arst),
        .bus (if0)
    );

    ram_delay_line #(.DATA_WIDTH(DW), .NUM_CH(1), .ADDR_WIDTH(AW),
                     .DEFAULT_LATENCY(20), .OUT_REG(1)) dut1 (
        .clk (clk),
        .arst(arst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic ce, input logic [DW-1:0] d, input logic fl,
                         input logic ld, input logic [AW-1:0] lat);
        if0.ce = ce; if0.din = d; if0.flush = fl; if0.cfg_load = ld; if0.cfg_latency = lat;
        if1.ce = ce; if1.din = d; if1.flush = fl; if1.cfg_load = ld; if1.cfg_latency = lat;
    endtask

    // Check status against the model, drive one cycle, then advance the model.
    task automatic step(input logic ce, input logic [DW-1:0] d, input logic fl,
                        input logic ld, input logic [AW-1:0] lat);
        exp_t e;
        bit   rp;
        @(negedge clk);
        chk("primed0", 32'(if0.primed), 32'(pm));
        chk("primed1", 32'(if1.primed), 32'(pm));
        chk("cur_latency0", 32'(if0.cur_latency), 32'(lm));
        chk("cur_latency1", 32'(if1.cur_latency), 32'(lm));
        chk("cfg_err0", 32'(if0.cfg_err), 32'(errm));
        chk("cfg_err1", 32'(if1.cfg_err), 32'(errm));
        drive(ce, d, fl, ld, lat);
        rp = fl | ld;
        if (ce) begin
            if (pm && !rp) begin
                e.data = hist[hist.size() - lm];
                e.due  = cyc + 1;
                q0.push_back(e);
                e.due  = cyc + 2;
                q1.push_back(e);
            end
            hist.push_back(d);
        end
        errm = ld && (lat == '0);
        if (ld) lm = (lat == '0) ? 1 : int'(lat);
        if (rp) begin
            fill_m = 0;
            pm     = 1'b0;
        end else if (ce && !pm) begin
            fill_m++;
            pm = (fill_m == lm);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        arst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        #1;
        chk("rst_dout0", 32'(if0.dout), 0);
        chk("rst_dout1", 32'(if1.dout), 0);
        chk("rst_valid0", 32'(if0.dout_valid), 0);
        chk("rst_valid1", 32'(if1.dout_valid), 0);
        chk("rst_primed0", 32'(if0.primed), 0);
        chk("rst_cur_latency0", 32'(if0.cur_latency), 20);
        chk("rst_cur_latency1", 32'(if1.cur_latency), 20);
        chk("rst_cfg_err0", 32'(if0.cfg_err), 0);
        q0.delete(); q1.delete(); hist.delete();
        lm = 20; fill_m = 0; pm = 1'b0; errm = 1'b0;
        lastv[0] = '0; lastv[1] = '0;
        repeat (n) @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic mon(input int idx, input logic v, input logic [DW-1:0] d);
        exp_t e;
        int   sz;
        sz = (idx == 0) ? q0.size() : q1.size();
        while (sz > 0) begin
            e = (idx == 0) ? q0[0] : q1[0];
            if (e.due >= cyc) break;
            chk($sformatf("dut%0d_valid_late", idx), 32'(cyc), 32'(e.due));
            if (idx == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            sz--;
        end
        if (v) begin
            if (sz == 0) begin
                chk($sformatf("dut%0d_unexpected_valid", idx), 32'(v), 0);
            end else begin
                chk($sformatf("dut%0d_dout", idx), 32'(d), 32'(e.data));
                chk($sformatf("dut%0d_valid_cycle", idx), 32'(cyc), 32'(e.due));
                if (idx == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                lastv[idx] = e.data;
            end
        end else begin
            chk($sformatf("dut%0d_dout_hold", idx), 32'(d), 32'(lastv[idx]));
        end
    endtask

    always @(negedge clk) begin
        if (!arst) begin
            mon(0, if0.dout_valid, if0.dout);
            mon(1, if1.dout_valid, if1.dout);
        end
    end

    initial begin
        arst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        do_reset(2);

        // Default latency, continuous samples.
        for (int i = 0; i < 45; i++) begin step(1'b1, DW'(k), 1'b0, 1'b0, '0); k++; end

        // L=4 with ce alternating.
        step(1'b1, DW'(k), 1'b0, 1'b1, AW'(4)); k++;
        for (int i = 0; i < 24; i++) begin step(1'(i % 2 == 0), DW'(k), 1'b0, 1'b0, '0); k++; end

        // Maximum latency across several pointer wraps.
        step(1'b1, DW'(k), 1'b0, 1'b1, AW'(255)); k++;
        for (int i = 0; i < 600; i++) begin step(1'b1, DW'(k), 1'b0, 1'b0, '0); k++; end

        // Back to 20, then shorten to 5 mid-stream.
        step(1'b1, DW'(k), 1'b0, 1'b1, AW'(20)); k++;
        for (int i = 0; i < 30; i++) begin step(1'b1, DW'(k), 1'b0, 1'b0, '0); k++; end
        step(1'b1, DW'(k), 1'b0, 1'b1, AW'(5)); k++;
        for (int i = 0; i < 15; i++) begin step(1'b1, DW'(k), 1'b0, 1'b0, '0); k++; end

        // Zero latency clamps; then flush together with a load.
        step(1'b1, DW'(k), 1'b0, 1'b1, AW'(0)); k++;
        for (int i = 0; i < 6; i++) begin step(1'b1, DW'(k), 1'b0, 1'b0, '0); k++; end
        step(1'b1, DW'(k), 1'b1, 1'b1, AW'(3)); k++;
        for (int i = 0; i < 10; i++) begin step(1'b1, DW'(k), 1'b0, 1'b0, '0); k++; end

        // Reset mid-stream, then re-prime at the default latency.
        do_reset(1);
        for (int i = 0; i < 30; i++) begin step(1'b1, DW'(k), 1'b0, 1'b0, '0); k++; end

        // Flush alone keeps the latency.
        step(1'b1, DW'(k), 1'b1, 1'b0, '0); k++;
        for (int i = 0; i < 25; i++) begin step(1'b1, DW'(k), 1'b0, 1'b0, '0); k++; end

        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("queue0_drained", 32'(q0.size()), 0);
        chk("queue1_drained", 32'(q1.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ram_delay_line.md
Name: ram_delay_line

Overview:
- Block-RAM-based, runtime-programmable delay line for sample streams; replaces fixed-latency RAM shift registers in video/DSP pipelines.
- Carries NUM_CH lanes of DATA_WIDTH bits that share one pointer pair and one simple_dual_port_ram instance.
- Adds clock enable, output valid, priming status, flush, and safe on-the-fly latency reload.

Parameters:
- DATA_WIDTH, 10: bits per channel.
- NUM_CH, 1: number of channels packed side by side (channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]).
- ADDR_WIDTH, 8: RAM depth is 2^ADDR_WIDTH. Legal latency range is 1 to 2^ADDR_WIDTH-1.
- DEFAULT_LATENCY, 20: latency loaded at reset. Must lie in the legal range.
- OUT_REG, 0: 1 adds one fabric register stage to dout and dout_valid.

Ports:
- arst  in  1: asynchronous reset, active-high.
- clk  in  1: clock. Reset arst, asynchronous, active-high; clock clk.
- ce  in  1: sample enable. din is accepted on each cycle with ce=1.
- din  in  DATA_WIDTH*NUM_CH: input samples.
- flush  in  1: synchronous re-prime request.
- cfg_load  in  1: load cfg_latency as the new latency.
- cfg_latency  in  ADDR_WIDTH: requested latency, in accepted samples.
- cur_latency  out  ADDR_WIDTH: active latency L.
- cfg_err  out  1: one-cycle pulse when a load was clamped.
- primed  out  1: L samples have been accepted since the last reset, flush or load.
- dout  out  DATA_WIDTH*NUM_CH: delayed samples.
- dout_valid  out  1: dout holds a new delayed sample this cycle.

Behaviour:
- Reset values: wptr=0, fill_cnt=0, L=DEFAULT_LATENCY, primed=0, dout_valid=0, dout=0, cfg_err=0.
- Write side:
  - On ce=1, write din at wptr, then wptr<=wptr+1.
  - wptr wraps modulo 2^ADDR_WIDTH.
  - wptr is never cleared except by arst.
- Read side:
  - raddr = wptr - L (mod 2^ADDR_WIDTH).
  - re = ce & primed.
  - For L>=1, raddr never equals the address being written in the same cycle.
- Priming:
  - While primed=0, each ce cycle increments fill_cnt.
  - primed = (fill_cnt == L). fill_cnt saturates at L.
- Output timing:
  - Sample n is accepted at cycle t with re=1, so n>=L.
  - dout_valid=1 at t+1 (t+2 if OUT_REG=1), with dout = sample n-L.
  - With continuous ce, total delay is L+1 clocks (L+2 with OUT_REG=1).
  - Gaps in ce stall the line. Delay counted in accepted samples is unchanged.
- dout masking and hold:
  - dout reads 0 until the first dout_valid after reset.
  - Afterwards dout holds the last valid sample when dout_valid=0.
  - RAM power-up contents never reach dout.
- cfg_load:
  - Next-cycle L = clamp(cfg_latency). Values of 0 clamp to 1; values above 2^ADDR_WIDTH-1 are unreachable by width.
  - cfg_err pulses for 1 cycle if clamping occurred.
  - fill_cnt<=0 and primed<=0.
  - The ce sample on the load cycle is written but not counted, and its read is suppressed.
- flush:
  - Same as cfg_load without changing L.
  - flush and cfg_load in the same cycle: load takes effect and the line re-primes once.
- Reset mid-stream: all state returns to reset values immediately; an in-flight dout_valid is dropped.
- Pointer wrap: no special handling; modulo arithmetic keeps raddr correct across the wrap.

Test Plan:
- Defaults, continuous ce, din=k at cycle k from cycle 0 -> first dout_valid at cycle 21 with dout=0; thereafter dout(t)=t-21 every cycle; primed rises at cycle 20.
- ce toggling 1,0,1,0, L=4 -> dout_valid only on the cycle after each accepted ce once primed; dout sequence is input samples 0,1,2,... with no gaps or repeats; 5th accepted sample yields sample 0.
- Run 600 cycles with L=255, ADDR_WIDTH=8 -> dout(t)=din(t-256) across wptr wraps, with no error in the cycles around wrap.
- Mid-stream cfg_load with cfg_latency=5 from L=20 -> primed and dout_valid drop; dout holds its last value; 5 accepted samples later (excluding the load cycle) dout_valid resumes at delay 6 clocks; cur_latency=5.
- cfg_load with cfg_latency=0 -> cur_latency=1 and cfg_err pulses 1 cycle. Then flush together with cfg_load=3 -> single re-prime with L=3.
- arst asserted mid-stream for 1 cycle -> dout=0, dout_valid=0, primed=0, cur_latency=20 immediately; re-prime behaves as in the first scenario. OUT_REG=1 run -> all timings above shift by +1 clock.
